// File: rtl/tawas_pkg.sv
// Shared ring-slot and request-entry types for the Tawas ring master.
// Slot layout (MSB first): vld rsp wr xch id[3:0] tag[4:0] mask[3:0] addr[21:2] data[31:0].
package tawas_pkg;

   localparam int SLOT_W = 69;
   localparam int ID_W   = 4;
   localparam int TAG_W  = 5;
   localparam int MASK_W = 4;
   localparam int ADDR_W = 20;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic              vld;
      logic              rsp;
      logic              wr;
      logic              xch;
      logic [ID_W-1:0]   id;
      logic [TAG_W-1:0]  tag;
      logic [MASK_W-1:0] mask;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } rcn_slot_t;

   typedef struct packed {
      logic              wr;
      logic              xch;
      logic [TAG_W-1:0]  thread;
      logic [MASK_W-1:0] mask;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } req_entry_t;

   function automatic rcn_slot_t make_req_slot(input req_entry_t e, input logic [ID_W-1:0] id);
      rcn_slot_t s;
      s.vld  = 1'b1;
      s.rsp  = 1'b0;
      s.wr   = e.wr;
      s.xch  = e.xch;
      s.id   = id;
      s.tag  = e.thread;
      s.mask = e.mask;
      s.addr = e.addr;
      s.data = e.data;
      return s;
   endfunction

endpackage

// File: rtl/tawas_fifo.sv
// Request buffer: power-of-two circular FIFO with show-ahead head output.
// Push while full and pop while empty are ignored.
module tawas_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == (PW+1)'(0));
   assign dout  = mem[rd_ptr];

   // qualify requests against occupancy
   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= (PW)'(0);
         wr_ptr <= (PW)'(0);
         count  <= (PW+1)'(0);
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (PW)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PW)'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // storage array
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/tawas_rcn_master.sv
// Ring master: buffers load/store requests, inserts them into empty ring slots,
// consumes responses addressed to MASTER_ID and returns read data to the thread.
module tawas_rcn_master
   import tawas_pkg::*;
#(
   parameter logic [3:0] MASTER_ID  = 4'd0,
   parameter int         THREADS    = 32,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   input  logic [4:0]         req_thread,
   input  logic               req_wr,
   input  logic               req_xch,
   input  logic [31:0]        req_addr,
   input  logic [2:0]         req_wbreg,
   input  logic [3:0]         req_mask,
   input  logic [31:0]        req_wdata,
   output logic [THREADS-1:0] thread_busy,
   output logic               fifo_full,
   output logic               wb_en,
   output logic [4:0]         wb_thread,
   output logic [2:0]         wb_reg,
   output logic [31:0]        wb_data,
   input  logic [SLOT_W-1:0]  rcn_in,
   output logic [SLOT_W-1:0]  rcn_out,
   output logic               err
);

   rcn_slot_t          slot_in;
   rcn_slot_t          slot_next;
   req_entry_t         push_entry;
   req_entry_t         head;
   logic               fifo_empty;
   logic               thread_ok;
   logic               tag_ok;
   logic               push;
   logic               drop;
   logic               match;
   logic               rsp_ok;
   logic               rsp_bad;
   logic               pop;
   logic               wb_hit;
   logic [THREADS-1:0] busy_next;
   logic [2:0]         wbreg_mem [THREADS];
   logic               addr_unused;

   assign slot_in     = rcn_in;
   assign addr_unused = &{1'b0, req_addr[31:22], req_addr[1:0]};

   tawas_fifo #(
      .WIDTH ($bits(req_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (push_entry),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // request acceptance, response consumption and slot selection
   always_comb begin
      push_entry = '{wr: req_wr, xch: req_xch, thread: req_thread, mask: req_mask,
                     addr: req_addr[21:2], data: req_wdata};
      thread_ok = (32'(req_thread) < THREADS);
      push      = req_valid && !fifo_full && thread_ok && !thread_busy[req_thread];
      drop      = req_valid && !push;

      match   = slot_in.vld && slot_in.rsp && (slot_in.id == MASTER_ID);
      tag_ok  = (32'(slot_in.tag) < THREADS);
      rsp_ok  = match && tag_ok && thread_busy[slot_in.tag];
      rsp_bad = match && !rsp_ok;
      wb_hit  = rsp_ok && (!slot_in.wr || slot_in.xch);

      // a consumed slot is free for reuse in the same cycle
      pop = (!slot_in.vld || match) && !fifo_empty;

      if (pop) begin
         slot_next = make_req_slot(head, MASTER_ID);
      end else if (match) begin
         slot_next = '0;
      end else begin
         slot_next = slot_in;
      end

      busy_next = thread_busy;
      if (rsp_ok) begin
         busy_next[slot_in.tag] = 1'b0;
      end else begin
         busy_next = busy_next;
      end
      if (push) begin
         busy_next[req_thread] = 1'b1;
      end else begin
         busy_next = busy_next;
      end
   end

   // registered ring slot, busy flags, writeback and sticky error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rcn_out     <= '0;
         thread_busy <= '0;
         wb_en       <= 1'b0;
         wb_thread   <= 5'd0;
         wb_reg      <= 3'd0;
         wb_data     <= 32'd0;
         err         <= 1'b0;
      end else begin
         rcn_out     <= slot_next;
         thread_busy <= busy_next;
         wb_en       <= wb_hit;
         err         <= err | drop | rsp_bad;
         if (wb_hit) begin
            wb_thread <= slot_in.tag;
            wb_reg    <= wbreg_mem[slot_in.tag];
            wb_data   <= slot_in.data;
         end
      end
   end

   // writeback register number stays local; it never travels on the ring
   always_ff @(posedge clk) begin
      if (push) wbreg_mem[req_thread] <= req_wbreg;
   end

endmodule

// File: tb/tb_tawas_rcn_master.sv
// Self-checking bench for tawas_rcn_master: per-cycle vector table for the ring
// and busy/full/err outputs, plus a writeback scoreboard checked by a monitor.
module tb_tawas_rcn_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [4:0]  req_thread;
   logic        req_wr;
   logic        req_xch;
   logic [31:0] req_addr;
   logic [2:0]  req_wbreg;
   logic [3:0]  req_mask;
   logic [31:0] req_wdata;
   logic [31:0] thread_busy;
   logic        fifo_full;
   logic        wb_en;
   logic [4:0]  wb_thread;
   logic [2:0]  wb_reg;
   logic [31:0] wb_data;
   logic [68:0] rcn_in;
   logic [68:0] rcn_out;
   logic        err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic        rv;
      logic [4:0]  th;
      logic        wr;
      logic        xch;
      logic [31:0] addr;
      logic [2:0]  wbreg;
      logic [31:0] wdata;
      logic [68:0] rin;
      logic [68:0] exp_out;
      logic [31:0] exp_busy;
      logic        exp_full;
      logic        exp_err;
      logic        exp_wb;
      logic [2:0]  exp_wbreg;
   } vec_t;

   typedef struct {
      int          due;
      logic [4:0]  th;
      logic [2:0]  rg;
      logic [31:0] d;
   } wb_exp_t;

   vec_t    vecs[$];
   wb_exp_t wb_q[$];
   wb_exp_t mon_e;

   tawas_rcn_master #(
      .MASTER_ID  (4'd0),
      .THREADS    (32),
      .FIFO_DEPTH (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_thread  (req_thread),
      .req_wr      (req_wr),
      .req_xch     (req_xch),
      .req_addr    (req_addr),
      .req_wbreg   (req_wbreg),
      .req_mask    (req_mask),
      .req_wdata   (req_wdata),
      .thread_busy (thread_busy),
      .fifo_full   (fifo_full),
      .wb_en       (wb_en),
      .wb_thread   (wb_thread),
      .wb_reg      (wb_reg),
      .wb_data     (wb_data),
      .rcn_in      (rcn_in),
      .rcn_out     (rcn_out),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [68:0] got, input logic [68:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [68:0] req_slot(input logic [4:0] t, input logic wr, input logic xch,
                                            input logic [31:0] a, input logic [31:0] d);
      return {1'b1, 1'b0, wr, xch, 4'd0, t, 4'hF, a[21:2], d};
   endfunction

   function automatic logic [68:0] rsp_slot(input logic [3:0] id, input logic [4:0] t,
                                            input logic wr, input logic xch, input logic [31:0] d);
      return {1'b1, 1'b1, wr, xch, id, t, 4'h0, 20'h00000, d};
   endfunction

   function automatic logic [68:0] fgn(input logic [31:0] n);
      return {1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 5'd9, 4'hF, 20'h12345, n};
   endfunction

   function automatic vec_t mkv(input logic rv, input logic [4:0] th, input logic wr, input logic xch,
                                input logic [31:0] addr, input logic [2:0] wbreg, input logic [31:0] wdata,
                                input logic [68:0] rin, input logic [68:0] exp_out, input logic [31:0] exp_busy,
                                input logic exp_full, input logic exp_err, input logic exp_wb,
                                input logic [2:0] exp_wbreg);
      vec_t v;
      v.rv = rv; v.th = th; v.wr = wr; v.xch = xch; v.addr = addr; v.wbreg = wbreg; v.wdata = wdata;
      v.rin = rin; v.exp_out = exp_out; v.exp_busy = exp_busy; v.exp_full = exp_full;
      v.exp_err = exp_err; v.exp_wb = exp_wb; v.exp_wbreg = exp_wbreg;
      return v;
   endfunction

   task automatic drive(input logic rv, input logic [4:0] th, input logic wr, input logic xch,
                        input logic [31:0] addr, input logic [2:0] wbreg, input logic [31:0] wdata,
                        input logic [68:0] rin);
      req_valid  = rv;
      req_thread = th;
      req_wr     = wr;
      req_xch    = xch;
      req_addr   = addr;
      req_wbreg  = wbreg;
      req_mask   = 4'hF;
      req_wdata  = wdata;
      rcn_in     = rin;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 69'd0);
   endtask

   task automatic expect_wb(input logic [68:0] rin, input logic [2:0] rg);
      wb_exp_t e;
      e.due = cyc + 1;
      e.th  = rin[60:56];
      e.rg  = rg;
      e.d   = rin[31:0];
      wb_q.push_back(e);
   endtask

   task automatic apply(input vec_t v, input int idx);
      drive(v.rv, v.th, v.wr, v.xch, v.addr, v.wbreg, v.wdata, v.rin);
      if (v.exp_wb) expect_wb(v.rin, v.exp_wbreg);
      step();
      check($sformatf("v%0d_rcn_out", idx), rcn_out, v.exp_out);
      check($sformatf("v%0d_busy", idx), {37'd0, thread_busy}, {37'd0, v.exp_busy});
      check($sformatf("v%0d_full", idx), {68'd0, fifo_full}, {68'd0, v.exp_full});
      check($sformatf("v%0d_err", idx), {68'd0, err}, {68'd0, v.exp_err});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rcn_out"}, rcn_out, 69'd0);
      check({tag, "_busy"}, {37'd0, thread_busy}, 69'd0);
      check({tag, "_full"}, {68'd0, fifo_full}, 69'd0);
      check({tag, "_wb_en"}, {68'd0, wb_en}, 69'd0);
      check({tag, "_wb_fields"}, {29'd0, wb_thread, wb_reg, wb_data}, 69'd0);
      check({tag, "_err"}, {68'd0, err}, 69'd0);
   endtask

   // writeback monitor: every pulse must match the next scoreboard entry on its due cycle
   always @(negedge clk) begin
      if (wb_en === 1'b1) begin
         if (wb_q.size() == 0) begin
            check("wb_unexpected", {68'd0, wb_en}, 69'd0);
         end else begin
            mon_e = wb_q.pop_front();
            check("wb_cycle", 69'(cyc), 69'(mon_e.due));
            check("wb_thread", {64'd0, wb_thread}, {64'd0, mon_e.th});
            check("wb_reg", {66'd0, wb_reg}, {66'd0, mon_e.rg});
            check("wb_data", {37'd0, wb_data}, {37'd0, mon_e.d});
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      idle();
      step();
      step();
      check_all_zero("reset");
      rst_n = 1'b1;

      vecs.push_back(mkv(1'b1, 5'd3, 1'b0, 1'b0, 32'h0000_1000, 3'd5, 32'd0, 69'd0, 69'd0, 32'h8, 1'b0, 1'b0, 1'b0, 3'd0));
      vecs.push_back(mkv(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 69'd0,
                         req_slot(5'd3, 1'b0, 1'b0, 32'h0000_1000, 32'd0), 32'h8, 1'b0, 1'b0, 1'b0, 3'd0));
      vecs.push_back(mkv(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, rsp_slot(4'd0, 5'd3, 1'b0, 1'b0, 32'hDEAD_BEEF),
                         69'd0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd5));
      vecs.push_back(mkv(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 69'd0, 69'd0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0));
      // four requests queued behind continuous foreign traffic, then a fifth while full
      vecs.push_back(mkv(1'b1, 5'd7, 1'b1, 1'b0, 32'h0000_4000, 3'd0, 32'hCAFE_F00D, fgn(32'd1), fgn(32'd1), 32'h80, 1'b0, 1'b0, 1'b0, 3'd0));
      vecs.push_back(mkv(1'b1, 5'd1, 1'b0, 1'b0, 32'h0000_2000, 3'd1, 32'd0, fgn(32'd2), fgn(32'd2), 32'h82, 1'b0, 1'b0, 1'b0, 3'd0));
      vecs.push_back(mkv(1'b1, 5'd2, 1'b1, 1'b1, 32'h0000_3000, 3'd2, 32'h1111_2222, fgn(32'd3), fgn(32'd3), 32'h86, 1'b0, 1'b0, 1'b0, 3'd0));
      vecs.push_back(mkv(1'b1, 5'd8, 1'b0, 1'b0, 32'h0000_5000, 3'd6, 32'd0, fgn(32'd4), fgn(32'd4), 32'h186, 1'b1, 1'b0, 1'b0, 3'd0));
      vecs.push_back(mkv(1'b1, 5'd9, 1'b0, 1'b0, 32'h0000_9000, 3'd1, 32'd0, fgn(32'd5), fgn(32'd5), 32'h186, 1'b1, 1'b1, 1'b0, 3'd0));
      vecs.push_back(mkv(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 69'd0,
                         req_slot(5'd7, 1'b1, 1'b0, 32'h0000_4000, 32'hCAFE_F00D), 32'h186, 1'b0, 1'b1, 1'b0, 3'd0));
      // write response: no writeback, slot refilled in the same cycle
      vecs.push_back(mkv(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, rsp_slot(4'd0, 5'd7, 1'b1, 1'b0, 32'd0),
                         req_slot(5'd1, 1'b0, 1'b0, 32'h0000_2000, 32'd0), 32'h106, 1'b0, 1'b1, 1'b0, 3'd0));
      // consume, insert and push all in one cycle
      vecs.push_back(mkv(1'b1, 5'd7, 1'b0, 1'b0, 32'h0000_6000, 3'd3, 32'd0, rsp_slot(4'd0, 5'd1, 1'b0, 1'b0, 32'hA5A5_A5A5),
                         req_slot(5'd2, 1'b1, 1'b1, 32'h0000_3000, 32'h1111_2222), 32'h184, 1'b0, 1'b1, 1'b1, 3'd1));
      vecs.push_back(mkv(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, rsp_slot(4'd0, 5'd2, 1'b1, 1'b1, 32'h3333_4444),
                         req_slot(5'd8, 1'b0, 1'b0, 32'h0000_5000, 32'd0), 32'h180, 1'b0, 1'b1, 1'b1, 3'd2));
      vecs.push_back(mkv(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, rsp_slot(4'd2, 5'd3, 1'b0, 1'b0, 32'hBEEF_0001),
                         rsp_slot(4'd2, 5'd3, 1'b0, 1'b0, 32'hBEEF_0001), 32'h180, 1'b0, 1'b1, 1'b0, 3'd0));
      vecs.push_back(mkv(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 69'd0,
                         req_slot(5'd7, 1'b0, 1'b0, 32'h0000_6000, 32'd0), 32'h180, 1'b0, 1'b1, 1'b0, 3'd0));
      vecs.push_back(mkv(1'b1, 5'd4, 1'b0, 1'b0, 32'h0000_7000, 3'd4, 32'd0, fgn(32'd6), fgn(32'd6), 32'h190, 1'b0, 1'b1, 1'b0, 3'd0));

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // reset with threads 7,8 outstanding and thread 4 queued
      idle();
      rst_n = 1'b0;
      step();
      check_all_zero("midrst");
      rst_n = 1'b1;
      step();
      check("midrst_queue_gone", rcn_out, 69'd0);
      drive(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, rsp_slot(4'd0, 5'd8, 1'b0, 1'b0, 32'h0BAD_0BAD));
      step();
      check("late_rsp_err", {68'd0, err}, 69'd1);
      check("late_rsp_consumed", rcn_out, 69'd0);
      check("late_rsp_busy", {37'd0, thread_busy}, 69'd0);

      // duplicate request from a busy thread is dropped
      idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      drive(1'b1, 5'd5, 1'b0, 1'b0, 32'h0000_8000, 3'd7, 32'd0, 69'd0);
      step();
      check("dup_first_busy", {37'd0, thread_busy}, 69'h20);
      check("dup_first_err", {68'd0, err}, 69'd0);
      drive(1'b1, 5'd5, 1'b0, 1'b0, 32'h0000_8000, 3'd2, 32'd0, 69'd0);
      step();
      check("dup_insert", rcn_out, req_slot(5'd5, 1'b0, 1'b0, 32'h0000_8000, 32'd0));
      check("dup_err", {68'd0, err}, 69'd1);
      idle();
      step();
      check("dup_not_queued", rcn_out, 69'd0);
      drive(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, rsp_slot(4'd0, 5'd5, 1'b0, 1'b0, 32'h5555_AAAA));
      expect_wb(rcn_in, 3'd7);
      step();
      check("dup_rsp_busy", {37'd0, thread_busy}, 69'd0);

      // response to an idle thread
      idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      drive(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, rsp_slot(4'd0, 5'd6, 1'b0, 1'b0, 32'h6666_6666));
      step();
      check("idle_tag_err", {68'd0, err}, 69'd1);
      check("idle_tag_consumed", rcn_out, 69'd0);
      idle();
      step();
      step();

      check("wb_queue_empty", 69'(wb_q.size()), 69'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tawas_rcn_master.md
TAWAS_RCN_MASTER -- requirements
Module: tawas_rcn_master

Interface
REQ-001 SHALL have parameter MASTER_ID, default 0, 4-bit ring master ID matched against the response id field.
REQ-002 SHALL have parameter THREADS, default 32, number of hardware threads tracked (legal 1..32).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, request buffer entries (power of 2, >=2).
REQ-004 SHALL have ports: clk  in  1  clock; single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  in  1  ring request strobe from load/store unit.
REQ-007 SHALL have ports req_thread  in  5, req_wr  in  1, req_xch  in  1, req_addr  in  32, req_wbreg  in  3, req_mask  in  4, req_wdata  in  32: request fields.
REQ-008 SHALL have port thread_busy  out  THREADS  bit t set while thread t has a request outstanding.
REQ-009 SHALL have port fifo_full  out  1  request buffer full.
REQ-010 SHALL have ports wb_en  out  1, wb_thread  out  5, wb_reg  out  3, wb_data  out  32: read/exchange writeback.
REQ-011 SHALL have ports rcn_in  in  69, rcn_out  out  69: ring slot in/out.
REQ-012 SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-013 Ring slot format SHALL be: [68] vld, [67] rsp, [66] wr, [65] xch, [64:61] id, [60:56] tag(thread), [55:52] mask, [51:32] addr[21:2], [31:0] data.
REQ-014 rcn_out SHALL be registered; ring latency through block is exactly 1 cycle.
REQ-015 rcn_in with vld=1, rsp=1, id==MASTER_ID SHALL be consumed: slot leaves as all-zero unless refilled per REQ-017.
REQ-016 Any other rcn_in SHALL pass to rcn_out unchanged one cycle later.
REQ-017 If the outgoing slot is empty (rcn_in vld=0 or consumed) and FIFO non-empty, FIFO head SHALL be inserted with vld=1, rsp=0, id=MASTER_ID, tag=thread.
REQ-018 req_valid with FIFO not full and thread not busy SHALL push the request and set thread_busy[req_thread] at the next edge.
REQ-019 Earliest rcn_out appearance SHALL be 2 cycles after req_valid (push edge, then insert edge).
REQ-020 Per-thread wbreg SHALL be stored locally at push; wbreg is not carried on the ring.
REQ-021 Consumed response with wr=0 or xch=1 SHALL assert wb_en for one cycle at next edge with wb_thread=tag, wb_reg=stored wbreg, wb_data=data.
REQ-022 Consumed response with wr=1, xch=0 SHALL not assert wb_en.
REQ-023 Any consumed response SHALL clear thread_busy[tag] at the next edge.
REQ-024 Push and consume in the same cycle SHALL both take effect; FIFO count unchanged if also inserting.
REQ-025 Response consume and insert of a new request in the same cycle SHALL be permitted (slot reuse).
REQ-026 req_valid when FIFO full, thread busy, or req_thread>=THREADS SHALL drop the request and set err.
REQ-027 Consumed response whose tag is not busy or >=THREADS SHALL be discarded (no wb_en) and set err.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_full asserted at count==FIFO_DEPTH.

Reset
REQ-029 On rst_n=0 at an edge: rcn_out=0, thread_busy=0, fifo empty, fifo_full=0, wb_en=0, wb_thread/wb_reg/wb_data=0, err=0.
REQ-030 Reset mid-operation SHALL discard all outstanding and buffered requests; late responses after reset SHALL set err per REQ-027.

Structure
REQ-031 Slot field bit positions, widths and the 69-bit slot type SHALL live in shared package tawas_pkg.
REQ-032 Request buffer SHALL be a sub-module tawas_fifo (parametrised width/depth, push/pop/full/empty).

Verification
REQ-033 Idle ring, req thread 3 read addr 0x0000_1000 wbreg 5 -> rcn_out at +2 = vld, id MASTER_ID, tag 3, addr field 0x00400; thread_busy[3]=1.
REQ-034 Return rsp tag 3 data 0xDEADBEEF on rcn_in -> next cycle wb_en=1, wb_thread=3, wb_reg=5, wb_data=0xDEADBEEF; thread_busy[3]=0.
REQ-035 Foreign traffic id=2 (MASTER_ID=0) continuous on rcn_in, 4 requests queued -> traffic passes unchanged, fifo_full=1, no insertion until a gap.
REQ-036 Fifth req_valid while full -> request dropped, err=1, thread_busy unchanged.
REQ-037 Write (wr=1) response tag 7 -> no wb_en, thread_busy[7] cleared; same-cycle slot refilled with queued request.
REQ-038 rst_n low with 2 outstanding and 1 queued -> all outputs zero next cycle; subsequent matching response sets err.
